// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch front end with PC, single-outstanding memory port,
// one output slot plus a one-entry skid buffer, and branch redirect with wrong-path flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        stallreq
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;
    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_q, state_d;
    logic        arm_q, arm_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_inst_q, slot_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        consume, ack;
    logic [31:0] tgt, pc_next;

    assign consume = valid_q & ~stall;
    assign ack     = mem_ack & req_q;
    assign tgt     = branch_target & ~32'h3;
    assign pc_next = pc_q + STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            arm_q       <= 1'b0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            slot_pc_q   <= '0;
            slot_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            slot_pc_q   <= slot_pc_d;
            slot_inst_q <= slot_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (branch_flag || arm_q) ? BUSY : IDLE;
            BUSY:    state_d = branch_flag ? (ack ? BUSY : DRAIN)
                                           : ((ack && valid_q && !consume) ? HOLD : BUSY);
            HOLD:    state_d = (branch_flag || consume) ? BUSY : HOLD;
            DRAIN:   state_d = (!branch_flag && ack) ? BUSY : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arm_d       = 1'b1;
        req_d       = req_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        slot_pc_d   = slot_pc_q;
        slot_inst_d = slot_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (branch_flag) begin
            pc_d        = tgt;
            valid_d     = 1'b0;
            slot_pc_d   = '0;
            slot_inst_d = '0;
            skid_pc_d   = '0;
            skid_inst_d = '0;
            req_d       = 1'b1;
            // an un-acked request must keep its address until memory answers it
            addr_d      = ((state_q == BUSY && !ack) || state_q == DRAIN) ? addr_q : tgt;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_q) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end
                end
                BUSY: begin
                    if (ack) begin
                        pc_d = pc_next;
                        if (!valid_q || consume) begin
                            slot_pc_d   = pc_q;
                            slot_inst_d = mem_rdata;
                            valid_d     = 1'b1;
                            addr_d      = pc_next;
                        end else begin
                            skid_pc_d   = pc_q;
                            skid_inst_d = mem_rdata;
                            req_d       = 1'b0;
                        end
                    end else if (consume) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        slot_pc_d   = skid_pc_q;
                        slot_inst_d = skid_inst_q;
                        skid_pc_d   = '0;
                        skid_inst_d = '0;
                        req_d       = 1'b1;
                        addr_d      = pc_q;
                    end
                end
                DRAIN: begin
                    if (ack) addr_d = pc_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign if_pc    = slot_pc_q;
    assign if_inst  = valid_q ? slot_inst_q : 32'h0;
    assign if_valid = valid_q;
    assign stallreq = rst & ~valid_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of inst_fetch against a simple instruction memory.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stallreq;

    logic        auto_ack = 1'b1;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = auto_ack ? w(mem_addr) : man_rdata;

    inst_fetch dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_valid", if_valid, 0);
        chk("rst_stallreq", stallreq, 0);
        tick;
        rst = 1'b1;
        tick;
        chk("idle_req", mem_req, 0);
        tick;
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 32'h0);
        chk("first_stallreq", stallreq, 1);
        tick;
        chk("seq0_pc", if_pc, 32'h0);
        chk("seq0_inst", if_inst, w(32'h0));
        chk("seq0_valid", if_valid, 1);
        chk("seq0_addr", mem_addr, 32'h4);
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("seq_pc", if_pc, 32'(4 * k));
            chk("seq_addr", mem_addr, 32'(4 * k + 4));
            chk("seq_valid", if_valid, 1);
        end
        chk("seq_inst10", if_inst, w(32'h10));
        stall = 1'b1;
        tick;
        chk("hold_req", mem_req, 0);
        chk("hold_pc", if_pc, 32'h10);
        tick;
        tick;
        chk("hold3_req", mem_req, 0);
        chk("hold3_pc", if_pc, 32'h10);
        chk("hold3_valid", if_valid, 1);
        stall = 1'b0;
        tick;
        chk("skid_pc", if_pc, 32'h14);
        chk("skid_inst", if_inst, w(32'h14));
        chk("skid_req", mem_req, 1);
        chk("skid_addr", mem_addr, 32'h18);
        tick;
        chk("after_skid_pc", if_pc, 32'h18);
        chk("after_skid_addr", mem_addr, 32'h1c);
        auto_ack = 1'b0;
        branch_flag = 1'b1;
        branch_target = 32'h103;
        tick;
        branch_flag = 1'b0;
        chk("drain_valid", if_valid, 0);
        chk("drain_inst", if_inst, 32'h0);
        chk("drain_stallreq", stallreq, 1);
        chk("drain_req", mem_req, 1);
        chk("drain_addr", mem_addr, 32'h1c);
        tick;
        chk("drain_wait_addr", mem_addr, 32'h1c);
        man_ack = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        tick;
        man_ack = 1'b0;
        auto_ack = 1'b1;
        chk("drain_done_valid", if_valid, 0);
        chk("drain_done_stallreq", stallreq, 1);
        chk("drain_done_addr", mem_addr, 32'h100);
        tick;
        chk("tgt_pc", if_pc, 32'h100);
        chk("tgt_inst", if_inst, w(32'h100));
        chk("tgt_valid", if_valid, 1);
        chk("tgt_addr", mem_addr, 32'h104);
        stall = 1'b1;
        branch_flag = 1'b1;
        branch_target = 32'h200;
        tick;
        branch_flag = 1'b0;
        stall = 1'b0;
        chk("br_ack_valid", if_valid, 0);
        chk("br_ack_inst", if_inst, 32'h0);
        chk("br_ack_addr", mem_addr, 32'h200);
        chk("br_ack_req", mem_req, 1);
        tick;
        chk("b200_pc", if_pc, 32'h200);
        stall = 1'b1;
        tick;
        chk("b200_hold_req", mem_req, 0);
        branch_flag = 1'b1;
        branch_target = 32'h300;
        tick;
        branch_flag = 1'b0;
        stall = 1'b0;
        chk("br_hold_valid", if_valid, 0);
        chk("br_hold_inst", if_inst, 32'h0);
        chk("br_hold_addr", mem_addr, 32'h300);
        chk("br_hold_req", mem_req, 1);
        branch_flag = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        tick;
        branch_flag = 1'b0;
        chk("top_addr", mem_addr, 32'hFFFF_FFFC);
        tick;
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", mem_addr, 32'h0);
        tick;
        chk("wrap_next_pc", if_pc, 32'h0);
        chk("wrap_next_addr", mem_addr, 32'h4);
        branch_flag = 1'b1;
        branch_target = 32'h3C;
        tick;
        branch_flag = 1'b0;
        tick;
        auto_ack = 1'b0;
        chk("pre_rst_addr", mem_addr, 32'h40);
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_valid", if_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_valid", if_valid, 0);
        chk("async_stallreq", stallreq, 0);
        chk("async_addr", mem_addr, 32'h0);
        tick;
        rst = 1'b1;
        auto_ack = 1'b1;
        tick;
        chk("re_idle_req", mem_req, 0);
        tick;
        chk("re_req", mem_req, 1);
        chk("re_addr", mem_addr, 32'h0);
        tick;
        chk("re_pc", if_pc, 32'h0);
        chk("re_valid", if_valid, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end; produces the IF-side `if_pc`/`if_inst` pair that the IF/ID pipeline register captures whenever its `stall` input is deasserted.
- Owns the PC and a single-outstanding req/ack read port to instruction memory.
- Holds one output slot plus a one-entry skid buffer, so a downstream stall never loses a returned word.
- Applies branch redirects from ID and flushes wrong-path words.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset and first fetched address
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  downstream hold; 1 = IF/ID does not capture this edge
branch_flag  in  1  one-cycle redirect request from ID
branch_target  in  32  redirect address; bits [1:0] forced to 0 internally
mem_req  out  1  instruction read request
mem_addr  out  32  read address, valid while mem_req=1
mem_ack  in  1  one-cycle pulse: mem_rdata valid for current request
mem_rdata  in  32  returned instruction word
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction; all-zero (NOP) when if_valid=0
if_valid  out  1  output slot holds a real instruction
stallreq  out  1  to pipeline control; equals ~if_valid outside reset

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, skid empty.
  - mem_req=0, mem_addr=RESET_PC.
  - if_pc=0, if_inst=0, if_valid=0, stallreq=0.
- Consume event: if_valid=1 and stall=0 at a rising edge. The slot is taken on that edge.
- Memory contract:
  - mem_req and mem_addr are registered outputs.
  - Once raised, mem_req stays 1 with mem_addr stable until the edge where mem_ack=1.
  - One request outstanding at most.
  - mem_ack while mem_req=0 is ignored.
- States:
  - IDLE: one cycle after reset release, then go to BUSY with mem_req=1, mem_addr=pc.
  - BUSY (mem_req=1; skid always empty here):
    - On ack, if the slot is empty or consumed this edge: slot <= {pc, rdata}, if_valid=1.
    - On ack otherwise: skid <= {pc, rdata} and go to HOLD (mem_req=0).
    - On every ack, pc += PC_STEP; if still BUSY, mem_addr follows the new pc next cycle, giving back-to-back requests.
    - Consume without ack: if_valid <= 0.
  - HOLD (mem_req=0; slot and skid full): on consume, slot <= skid, skid cleared, go to BUSY with mem_addr=pc.
  - DRAIN (mem_req=1, old address held): on ack, discard rdata, go to BUSY with mem_addr=pc (the target).
- Branch (branch_flag=1 at an edge) has priority over consume and ack:
  - pc <= {branch_target[31:2], 2'b00}; slot and skid cleared (if_valid <= 0).
  - BUSY without ack -> DRAIN.
  - BUSY with ack: data discarded, stay BUSY, next mem_addr = target.
  - IDLE/HOLD -> BUSY with target.
  - DRAIN + branch: pc updated, stay DRAIN.
- No delay-slot handling: every word fetched after the branch edge is discarded.
- Latency:
  - First mem_req occurs 2 cycles after reset release.
  - if_valid rises on the edge that samples mem_ack.
  - With zero-wait memory (ack in the first request cycle) and stall=0: one instruction per cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 without error.
- Reset asserted mid-request drops mem_req asynchronously; memory must abandon the request.

Test Plan:
1. Reset release, memory acks in the first request cycle, stall=0 -> mem_addr 0,4,8,... on consecutive cycles; if_pc follows one cycle later with if_valid=1 continuously; first mem_req 2 cycles after release.
2. stall=1 for 3 cycles while a word at pc=0x10 is presented and ack returns 0x14's word -> HOLD with mem_req=0, if_pc holds 0x10; after stall drops, if_pc=0x10 consumed then 0x14, then mem_addr=0x18. No word lost or duplicated.
3. branch_flag with target 0x103 while BUSY with ack 2 cycles late -> DRAIN; old-address ack discarded (if_valid stays 0, stallreq=1); next mem_addr=0x100; first valid if_pc=0x100.
4. branch_flag on the same edge as mem_ack and a pending skid word -> both discarded, if_inst=0; next request to the target.
5. pc=32'hFFFF_FFFC, ack -> next mem_addr=0.
6. Assert rst mid-request (mem_req=1, mem_addr=0x40) -> mem_req, if_valid and stallreq drop immediately without a clock edge; after release, refetch starts at RESET_PC.
